// File: rtl/axi_lite_reg_write_ctrl.sv
// AXI4-Lite write slave: captures AW/W in any order, byte-merges WSTRB lanes with the
// addressed register's current value, pulses one load strobe, then returns B.
module axi_lite_reg_write_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REGS   = 16,
  parameter int IDX_W      = $clog2(NUM_REGS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  output logic [IDX_W-1:0]        reg_idx,
  input  logic [DATA_WIDTH-1:0]   reg_q,
  output logic [NUM_REGS-1:0]     reg_load,
  output logic [DATA_WIDTH-1:0]   reg_wdata
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int WIDX_W = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {IDLE, WRITE, RESP} state_t;

  state_t              state_q, state_d;
  logic                aw_held_q, aw_held_d;
  logic                w_held_q, w_held_d;
  logic                awready_q, awready_d;
  logic                wready_q, wready_d;
  logic                bvalid_q, bvalid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic [WIDX_W-1:0]   widx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]   wstrb_q;

  logic aw_hs, w_hs, in_range;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] new_d,
    input logic [DATA_WIDTH-1:0] old_d,
    input logic [STRB_W-1:0]     strb
  );
    logic [DATA_WIDTH-1:0] r;
    for (int b = 0; b < STRB_W; b++) begin
      r[8*b +: 8] = strb[b] ? new_d[8*b +: 8] : old_d[8*b +: 8];
    end
    return r;
  endfunction

  assign aw_hs    = s_axi_awvalid & awready_q;
  assign w_hs     = s_axi_wvalid & wready_q;
  // Full word index is kept so addresses beyond the bank are detected, not aliased.
  assign in_range = 32'(widx_q) < 32'(NUM_REGS);

  always_comb begin
    state_d   = state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awready_d = 1'b0;
    wready_d  = 1'b0;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    unique case (state_q)
      IDLE: begin
        aw_held_d = aw_held_q | aw_hs;
        w_held_d  = w_held_q | w_hs;
        if (aw_held_d && w_held_d) begin
          state_d = WRITE;
        end else begin
          awready_d = ~aw_held_d;
          wready_d  = ~w_held_d;
        end
      end
      WRITE: begin
        state_d  = RESP;
        bvalid_d = 1'b1;
        bresp_d  = in_range ? 2'b00 : 2'b10;
      end
      RESP: begin
        if (s_axi_bready) begin
          state_d   = IDLE;
          bvalid_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      widx_q    <= '0;
    end else begin
      state_q   <= state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      if (aw_hs) widx_q <= s_axi_awaddr[ADDR_WIDTH-1:2];
    end
  end

  // Write payload needs no reset: it is only consumed after a fresh W handshake.
  always_ff @(posedge clk) begin
    if (w_hs) begin
      wdata_q <= s_axi_wdata;
      wstrb_q <= s_axi_wstrb;
    end
  end

  always_comb begin
    reg_load  = '0;
    reg_wdata = '0;
    if (state_q == WRITE) begin
      reg_wdata = merge_bytes(wdata_q, reg_q, wstrb_q);
      if (in_range) reg_load[widx_q[IDX_W-1:0]] = 1'b1;
    end
  end

  assign reg_idx       = widx_q[IDX_W-1:0];
  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;

endmodule

// File: tb/tb_axi_lite_reg_write_ctrl.sv
// Bench for axi_lite_reg_write_ctrl: register-bank model, directed writes, scoreboard monitor.
module tb_axi_lite_reg_write_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  awaddr;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [3:0]  reg_idx;
  logic [31:0] reg_q;
  logic [15:0] reg_load;
  logic [31:0] reg_wdata;

  typedef struct {
    logic [15:0] load;
    logic [31:0] wdata;
    logic [1:0]  resp;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          load_total = 0;
  int          txn_loads = 0;
  int          last_load_cyc = 0;
  int          prev_load_cyc = 0;
  logic [15:0] obs_load = '0;
  logic [31:0] obs_wdata = '0;
  logic [31:0] bank [16];

  axi_lite_reg_write_ctrl #(
    .DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_REGS(16), .IDX_W(4)
  ) dut (
    .clk(clk), .reset(reset),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .reg_idx(reg_idx), .reg_q(reg_q), .reg_load(reg_load), .reg_wdata(reg_wdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) bank[i] <= 32'h0;
      bank[1] <= 32'h11111111;
      bank[3] <= 32'hAABBCCDD;
      bank[5] <= 32'h55667788;
      bank[6] <= 32'h0BADCAFE;
    end else begin
      for (int i = 0; i < 16; i++) if (reg_load[i]) bank[i] <= reg_wdata;
    end
  end

  assign reg_q = bank[reg_idx];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input bit need_aw, input bit need_w);
    for (int i = 0; i < 40; i++) begin
      if ((!need_aw || awready) && (!need_w || wready)) return;
      tick();
    end
    chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_both(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    wait_ready(1'b1, 1'b1);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic send_aw(input logic [7:0] a);
    awaddr = a; awvalid = 1'b1;
    wait_ready(1'b1, 1'b0);
    tick();
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    wdata = d; wstrb = s; wvalid = 1'b1;
    wait_ready(1'b0, 1'b1);
    tick();
    wvalid = 1'b0;
  endtask

  task automatic push(input logic [15:0] l, input logic [31:0] d, input logic [1:0] r);
    exp_t e;
    e.load = l; e.wdata = d; e.resp = r;
    sb.push_back(e);
  endtask

  initial begin
    exp_t e;
    reset = 1'b1; awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0;
    wvalid = 1'b0; bready = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (!reset) begin
          if (reg_load != 16'h0) begin
            chk("load_onehot", 32'($onehot(reg_load)), 32'd1);
            txn_loads++;
            load_total++;
            obs_load  = reg_load;
            obs_wdata = reg_wdata;
            prev_load_cyc = last_load_cyc;
            last_load_cyc = cyc;
          end
          if (bvalid && bready) begin
            if (sb.size() == 0) begin
              chk("unexpected_bresp", 32'd1, 32'd0);
            end else begin
              e = sb.pop_front();
              chk("sb_bresp", 32'(bresp), 32'(e.resp));
              chk("sb_load", 32'(obs_load), 32'(e.load));
              if (e.load != 16'h0) chk("sb_wdata", obs_wdata, e.wdata);
              chk("sb_nloads", txn_loads, (e.load != 16'h0) ? 32'd1 : 32'd0);
            end
            txn_loads = 0;
            obs_load  = '0;
            obs_wdata = '0;
          end
        end
      end
    join_none

    // Reset values while held, then first cycle after release
    #1;
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("post_rst_awready", 32'(awready), 32'd1);
    chk("post_rst_wready", 32'(wready), 32'd1);

    // Mid-cycle reset with awvalid high
    @(negedge clk);
    awaddr = 8'h08; awvalid = 1'b1; reset = 1'b1;
    #1;
    chk("midrst_awready", 32'(awready), 32'd0);
    chk("midrst_wready", 32'(wready), 32'd0);
    chk("midrst_bvalid", 32'(bvalid), 32'd0);
    chk("midrst_bresp", 32'(bresp), 32'd0);
    chk("midrst_load", 32'(reg_load), 32'd0);
    chk("midrst_wdata", reg_wdata, 32'd0);
    chk("midrst_idx", 32'(reg_idx), 32'd0);
    @(negedge clk);
    reset = 1'b0; awvalid = 1'b0;
    tick();
    chk("rel_awready", 32'(awready), 32'd1);
    chk("rel_wready", 32'(wready), 32'd1);
    chk("rst_no_load", load_total, 32'd0);

    // Simultaneous AW/W
    push(16'h0004, 32'hDEADBEEF, 2'b00);
    send_both(8'h08, 32'hDEADBEEF, 4'hF);
    chk("sim_c1_load", 32'(reg_load), 32'h0004);
    chk("sim_c1_wdata", reg_wdata, 32'hDEADBEEF);
    chk("sim_c1_idx", 32'(reg_idx), 32'd2);
    chk("sim_c1_bvalid", 32'(bvalid), 32'd0);
    tick();
    chk("sim_c2_load", 32'(reg_load), 32'h0);
    chk("sim_c2_bvalid", 32'(bvalid), 32'd1);
    chk("sim_c2_bresp", 32'(bresp), 32'd0);
    tick();
    chk("sim_c3_awready", 32'(awready), 32'd1);
    chk("sim_c3_wready", 32'(wready), 32'd1);

    // W first, 3-cycle gap, then AW, with partial strobe
    push(16'h0008, 32'hAABB3344, 2'b00);
    send_w(32'h11223344, 4'h3);
    chk("wfirst_wready", 32'(wready), 32'd0);
    chk("wfirst_awready", 32'(awready), 32'd1);
    repeat (3) tick();
    chk("gap_wready", 32'(wready), 32'd0);
    chk("gap_load", 32'(reg_load), 32'h0);
    send_aw(8'h0C);
    chk("wfirst_load", 32'(reg_load), 32'h0008);
    chk("wfirst_merge", reg_wdata, 32'hAABB3344);
    wait_ready(1'b1, 1'b1);

    // Out-of-range address
    push(16'h0000, 32'h0, 2'b10);
    send_both(8'h40, 32'hFFFFFFFF, 4'hF);
    chk("oor_load", 32'(reg_load), 32'h0);
    tick();
    chk("oor_bvalid", 32'(bvalid), 32'd1);
    chk("oor_bresp", 32'(bresp), 32'd2);
    wait_ready(1'b1, 1'b1);

    // Zero strobe reloads the current value
    push(16'h0040, 32'h0BADCAFE, 2'b00);
    send_both(8'h1B, 32'h12345678, 4'h0);
    chk("zstrb_wdata", reg_wdata, 32'h0BADCAFE);
    wait_ready(1'b1, 1'b1);

    // B backpressure with a pending AW
    bready = 1'b0;
    push(16'h0010, 32'h12345678, 2'b00);
    send_both(8'h10, 32'h12345678, 4'hF);
    tick();
    awaddr = 8'h14; awvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_bvalid", 32'(bvalid), 32'd1);
      chk("bp_bresp", 32'(bresp), 32'd0);
      chk("bp_awready", 32'(awready), 32'd0);
      chk("bp_wready", 32'(wready), 32'd0);
      tick();
    end
    push(16'h0020, 32'hCAFE7788, 2'b00);
    bready = 1'b1;
    tick();
    chk("bp_rel_bvalid", 32'(bvalid), 32'd0);
    chk("bp_rel_awready", 32'(awready), 32'd1);
    tick();
    awvalid = 1'b0;
    chk("bp_aw_taken", 32'(awready), 32'd0);
    chk("bp_w_open", 32'(wready), 32'd1);
    send_w(32'hCAFEF00D, 4'hC);
    chk("awfirst_load", 32'(reg_load), 32'h0020);
    wait_ready(1'b1, 1'b1);

    // Back-to-back writes
    push(16'h0001, 32'h00000001, 2'b00);
    push(16'h0002, 32'h11A511A5, 2'b00);
    send_both(8'h00, 32'h00000001, 4'hF);
    send_both(8'h04, 32'hA5A5A5A5, 4'h5);
    wait_ready(1'b1, 1'b1);
    chk("b2b_spacing", last_load_cyc - prev_load_cyc, 32'd3);

    for (int i = 0; i < 50; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
    chk("sb_empty", sb.size(), 32'd0);
    chk("load_total", load_total, 32'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_lite_reg_write_ctrl.md
Name: axi_lite_reg_write_ctrl

Overview:
AXI4-Lite write-channel slave that sits directly upstream of the controller's bank of load_reg-style storage registers. It accepts AW and W beats in either order, merges WSTRB byte lanes with the addressed register's current value, and issues a one-cycle load strobe plus merged data to exactly one register. It then returns a B response. Reads are handled by a separate block.

Parameters:
DATA_WIDTH, 32, AXI data width and register width; must be a multiple of 8.
ADDR_WIDTH, 8, AXI byte-address width.
NUM_REGS, 16, number of downstream registers; word index = awaddr[ADDR_WIDTH-1:2].
IDX_W, $clog2(NUM_REGS), width of the register index.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high reset.
s_axi_awaddr  in  ADDR_WIDTH  write byte address.
s_axi_awvalid  in  1  AW valid.
s_axi_awready  out  1  AW ready.
s_axi_wdata  in  DATA_WIDTH  write data.
s_axi_wstrb  in  DATA_WIDTH/8  byte strobes.
s_axi_wvalid  in  1  W valid.
s_axi_wready  out  1  W ready.
s_axi_bresp  out  2  00 = OKAY, 10 = SLVERR.
s_axi_bvalid  out  1  B valid.
s_axi_bready  in  1  B ready.
reg_idx  out  IDX_W  captured word index; drives the external current-value mux.
reg_q  in  DATA_WIDTH  current value of register[reg_idx], combinational from the bank.
reg_load  out  NUM_REGS  one-hot load strobes, one per register.
reg_wdata  out  DATA_WIDTH  merged data, shared by all registers.

Behaviour:
- Reset (asynchronous, active-high) drives the following and abandons any partially captured transaction; no load is issued:
  - State = IDLE; aw_held = w_held = 0.
  - awready = wready = bvalid = 0; bresp = 00.
  - reg_load = 0; reg_wdata = 0; reg_idx = 0.
- The first cycle after reset deassertion is IDLE with awready and wready both 1.
- State machine:
  - IDLE:
    - awready = !aw_held; wready = !w_held; both are registered outputs.
    - An AW handshake captures the address index and sets aw_held. A W handshake captures wdata/wstrb and sets w_held.
    - Both handshakes may occur in the same cycle. Either order is legal, and a gap of any length between them is legal.
    - When both are held, or become held at this edge, go to WRITE.
    - After a held channel completes, its ready drops to 0 on the next cycle.
  - WRITE (exactly 1 cycle):
    - awready = wready = 0.
    - If index < NUM_REGS: reg_load[index] = 1.
    - For each byte b, reg_wdata byte b = wstrb[b] ? wdata byte b : reg_q byte b.
    - Go to RESP with bresp = 00 if the index was in range, else 10.
    - An out-of-range index produces no load (reg_load all 0).
  - RESP:
    - bvalid = 1 and bresp stay stable until bready = 1.
    - On the bready edge: bvalid = 0, aw_held = w_held = 0, go to IDLE, and assert awready = wready = 1 the next cycle.
- reg_load and reg_wdata are combinational from state and captured registers. reg_load is at most one-hot and is nonzero only in WRITE.
- Latency: with both channels handshaking at edge 0, WRITE is cycle 1 and the register updates at edge 2. bvalid is 1 in cycle 2; with bready held at 1, ready returns in cycle 3.
- Minimum throughput: one write per 3 cycles.
- wstrb = 0 is accepted; it loads reg_q unchanged and returns OKAY.
- awaddr[1:0] is ignored.
- Only one transaction is outstanding; no further AW or W is accepted until B completes.

Test Plan:
- Reset: assert reset mid-cycle with awvalid = 1 -> all outputs 0 immediately; awready = wready = 1 the cycle after release; reg_load never pulses.
- Simultaneous AW/W: awaddr = 0x08, wdata = 0xDEADBEEF, wstrb = 0xF -> reg_load = 0x0004 for exactly 1 cycle; reg_wdata = 0xDEADBEEF; bvalid in cycle 2 with bresp = 00.
- W before AW, 3-cycle gap, wstrb = 0x3, wdata = 0x11223344, reg_q = 0xAABBCCDD, awaddr = 0x0C -> wready drops after the W beat; reg_wdata = 0xAABB3344; reg_load = 0x0008.
- Out of range: awaddr = 0x40 with NUM_REGS = 16 -> reg_load stays 0; bresp = 10; bvalid = 1.
- Backpressure: bready held 0 for 5 cycles -> bvalid and bresp stable; awready = wready = 0; a new awvalid is not accepted until after the bready edge.
- Back-to-back writes to 0x00 then 0x04 with bready = 1 -> two loads 3 cycles apart; reg_load = 0x0001 then 0x0002; two OKAY responses.
